// File: rtl/maze_memory.sv
// 2^maze_width x 2^maze_width maze cell store: host loader fills it row-major,
// the solver reads walls and marks path cells, and the host dumps it for scoring.
module maze_memory #(
  parameter int maze_width = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic                    load_wall,
  output logic                    load_ready,
  output logic                    ready,
  input  logic                    dump_en,
  input  logic [maze_width-1:0]   dump_row,
  input  logic [maze_width-1:0]   dump_col,
  output logic [1:0]              dump_data,
  output logic [2*maze_width:0]   path_count,
  output logic                    wall_write_err
);

  localparam int unsigned aw    = 2 * maze_width;
  localparam int unsigned cells = 1 << aw;
  localparam logic [aw:0] count_max = (aw+1)'(cells);

  localparam logic [1:0] cell_free = 2'd0;
  localparam logic [1:0] cell_wall = 2'd1;
  localparam logic [1:0] cell_path = 2'd2;

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_load  = 2'd1;
  localparam logic [1:0] st_ready = 2'd2;

  logic [1:0]    state;
  logic [aw-1:0] cnt;
  logic [1:0]    mem [cells];

  logic [aw-1:0] solver_addr;
  logic [aw-1:0] dump_addr;
  logic [1:0]    solver_cell;
  logic          load_beat;
  logic          last_beat;
  logic          solver_ok;
  logic          mark;
  logic          hit_wall;

  assign solver_addr = {row, col};
  assign dump_addr   = {dump_row, dump_col};
  assign solver_cell = mem[solver_addr];

  assign load_ready = (state == st_load);
  assign ready      = (state == st_ready);

  assign load_beat = load_ready && load_valid;
  assign last_beat = load_beat && (cnt == '1);
  // A load_start in READY takes priority and drops a concurrent solver write.
  assign solver_ok = ready && !load_start;
  assign mark      = solver_ok && maze_we && (solver_cell == cell_free);
  assign hit_wall  = solver_ok && maze_we && (solver_cell == cell_wall);

  always_ff @(posedge clk) begin
    if (load_beat) begin
      mem[cnt] <= load_wall ? cell_wall : cell_free;
    end else if (mark) begin
      mem[solver_addr] <= cell_path;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= st_idle;
      cnt            <= '0;
      maze_in        <= 1'b0;
      dump_data      <= '0;
      path_count     <= '0;
      wall_write_err <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (load_start) begin
            state          <= st_load;
            cnt            <= '0;
            path_count     <= '0;
            wall_write_err <= 1'b0;
          end
        end
        st_load: begin
          if (load_beat) begin
            cnt <= cnt + aw'(1);
            if (last_beat) begin
              state <= st_ready;
            end
          end
        end
        st_ready: begin
          if (maze_oe) begin
            maze_in <= (solver_cell == cell_wall);
          end
          if (load_start) begin
            state          <= st_load;
            cnt            <= '0;
            path_count     <= '0;
            wall_write_err <= 1'b0;
          end else begin
            if (mark && (path_count != count_max)) begin
              path_count <= path_count + (aw+1)'(1);
            end
            if (hit_wall) begin
              wall_write_err <= 1'b1;
            end
          end
        end
        default: state <= st_idle;
      endcase

      if (dump_en && (state == st_idle || state == st_ready)) begin
        dump_data <= mem[dump_addr];
      end
    end
  end

endmodule
